alt_vipcti130_vid2is_seq: RTL and testbench
===========================================

Name: alt_vipcti130_Vid2IS_seq

Overview:
- Run-time sequencer for the Vid2IS capture datapath. Sits between the control register block (enable, overflow_sticky) and the input FIFO/write logic.
- Decides when the FIFO may accept pixels and when the outgoing ImageStream may run. Capture starts only on a field-0 boundary after the input resolution has been stable long enough.
- On FIFO overflow it disables writes, flushes the FIFO, clears the sticky flag and re-arms automatically.

Parameters:
- USED_WORDS_WIDTH, 15, width of FIFO usedw.
- STABLE_CYCLES, 16, consecutive cycles of stable && resolution_valid required before arming; must be >= 1.
- INTERLACED, 1, when 1 capture starts only on sof with field=0; when 0 the field input is ignored.
- WATCHDOG_CYCLES, 2**20, WAIT_SOF timeout in clocks; used only with the optional feature.

Ports:
- clk  in  1  capture clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level enable from the control register.
- stable  in  1  resolution detector stable.
- resolution_valid  in  1  resolution detector valid.
- sof  in  1  one-cycle start-of-field pulse, aligned with the first active pixel.
- field  in  1  field id qualifying sof.
- overflow_sticky  in  1  FIFO overflow sticky flag.
- usedw  in  USED_WORDS_WIDTH  FIFO fill level.
- fifo_write_en  out  1  gates pixel writes into the FIFO.
- fifo_flush  out  1  FIFO read-discard request.
- is_output_enable  out  1  allows the outgoing ImageStream state machine to run.
- clear_overflow_sticky  out  1  one-cycle pulse.
- state  out  3  current state encoding, for readback.
- restart_count  out  8  saturating count of overflow recoveries.
- timeout_irq  out  1  one-cycle pulse; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (rst_n=0, async): state=IDLE (0), all outputs 0, stability counter 0, restart_count 0. Assertion mid-operation aborts immediately with no flush.
- State encoding: IDLE=0, WAIT_STABLE=1, WAIT_SOF=2, RUN=3, STOP=4, FLUSH=5, RECOVER=6. All outputs are registered, so each takes effect the cycle after its state is entered.
- IDLE: enable=1 goes to WAIT_STABLE.
- WAIT_STABLE:
  - The counter increments while stable && resolution_valid, and resets to 0 otherwise.
  - When the counter reaches STABLE_CYCLES-1 with the condition still true, go to WAIT_SOF.
  - enable=0 goes to IDLE.
- WAIT_SOF:
  - sof && (field==0 || !INTERLACED) goes to RUN.
  - fifo_write_en=1 on the cycle after that sof. The sof pixel itself is not captured, so the upstream pipeline delays data by one cycle.
  - Loss of stable goes to WAIT_STABLE.
  - enable=0 goes to IDLE.
- RUN: fifo_write_en=1, is_output_enable=1.
  - overflow_sticky=1 goes to FLUSH.
  - Else loss of stable or resolution_valid goes to FLUSH.
  - Else enable=0 goes to STOP.
- STOP:
  - Writes continue until the next sof (any field), then go to IDLE. fifo_write_en drops the cycle after that sof, so only complete fields enter the FIFO.
  - overflow_sticky still takes priority and goes to FLUSH.
- FLUSH:
  - fifo_write_en=0, is_output_enable=0, fifo_flush=1.
  - When usedw==0, pulse clear_overflow_sticky for one cycle, deassert fifo_flush and go to RECOVER.
  - If overflow_sticky was 0 on entry, still pulse; the pulse is harmless.
- RECOVER:
  - Wait for overflow_sticky==0, then increment restart_count (saturate at 255).
  - Go to WAIT_STABLE if enable=1, else IDLE.
- Priority within one cycle: overflow > stable loss > enable drop > sof.
- sof arriving in the same cycle as the stability threshold is not taken; arming begins the next cycle.

Optional Feature:
- Macro: VID2IS_SEQ_WATCHDOG_EN.
- Defined: a 21-bit counter runs in WAIT_SOF and clears on any other state. On reaching WATCHDOG_CYCLES-1, go to WAIT_STABLE and pulse timeout_irq for one cycle.
- Undefined: no counter, timeout_irq tied 0, WAIT_SOF waits indefinitely.

Decomposition:
- Shared package alt_vipcti130_Vid2IS_pkg holds the state localparams (3-bit codes) and the RESTART_COUNT_WIDTH=8 constant, for reuse by the control block readback.
- One natural sub-module: alt_vipcti130_Vid2IS_stable_filter, the STABLE_CYCLES persistence counter producing an armed pulse/level. The FSM stays in the top.

Test Plan:
- Arming, STABLE_CYCLES=4: enable=1 with stable/valid held 4 cycles, then sof field=1 followed by sof field=0 -> state 1→2→3 only on the field-0 sof; fifo_write_en=1 exactly one cycle after that sof.
- Stable glitch: stable drops for 1 cycle after 3 good cycles -> counter restarts; WAIT_SOF is reached only after 4 further consecutive good cycles.
- Overflow: in RUN assert overflow_sticky, usedw decrements 5→0 -> fifo_write_en=0 next cycle, fifo_flush high until usedw==0, one clear_overflow_sticky pulse, restart_count 0→1, then back to state 1.
- Graceful stop: enable=0 mid-field in RUN -> writes continue to the next sof, then state=0; overflow during STOP -> FLUSH instead.
- Async reset mid-FLUSH: rst_n low for 1 cycle -> all outputs 0 immediately, state=0, restart_count=0.
- Saturation/watchdog: 256 overflow recoveries -> restart_count stays 255. With VID2IS_SEQ_WATCHDOG_EN and WATCHDOG_CYCLES=100 and no sof -> timeout_irq pulse at cycle 100 of WAIT_SOF, state=1.

Source files
------------

// File: rtl/alt_vipcti130_vid2is_pkg.sv
// alt_vipcti130_vid2is_pkg: sequencer state codes and restart counter width shared with the control readback
package alt_vipcti130_vid2is_pkg;
  localparam int RESTART_COUNT_WIDTH = 8;
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_STABLE = 3'd1,
    S_WAIT_SOF    = 3'd2,
    S_RUN         = 3'd3,
    S_STOP        = 3'd4,
    S_FLUSH       = 3'd5,
    S_RECOVER     = 3'd6
  } seq_state_e;
  function automatic logic [RESTART_COUNT_WIDTH-1:0] sat_inc(input logic [RESTART_COUNT_WIDTH-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/alt_vipcti130_vid2is_seq_if.sv
// alt_vipcti130_vid2is_seq_if: control, video status and FIFO signals around the capture sequencer
interface alt_vipcti130_vid2is_seq_if #(parameter int USED_WORDS_WIDTH = 15);
  import alt_vipcti130_vid2is_pkg::*;
  logic enable;
  logic stable;
  logic resolution_valid;
  logic sof;
  logic field;
  logic overflow_sticky;
  logic [USED_WORDS_WIDTH-1:0] usedw;
  logic fifo_write_en;
  logic fifo_flush;
  logic is_output_enable;
  logic clear_overflow_sticky;
  logic [2:0] state;
  logic [RESTART_COUNT_WIDTH-1:0] restart_count;
  logic timeout_irq;
  modport slave (
    input  enable, stable, resolution_valid, sof, field, overflow_sticky, usedw,
    output fifo_write_en, fifo_flush, is_output_enable, clear_overflow_sticky, state, restart_count, timeout_irq
  );
  modport master (
    output enable, stable, resolution_valid, sof, field, overflow_sticky, usedw,
    input  fifo_write_en, fifo_flush, is_output_enable, clear_overflow_sticky, state, restart_count, timeout_irq
  );
endinterface

// File: rtl/alt_vipcti130_vid2is_stable_filter.sv
// alt_vipcti130_vid2is_stable_filter: armed pulses once good has held STABLE_CYCLES consecutive cycles while run
module alt_vipcti130_vid2is_stable_filter #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic good,
  output logic armed
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  logic [CW-1:0] cnt;
  assign armed = run && good && cnt == CW'(STABLE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= run && good && !armed ? cnt + CW'(1) : '0;
endmodule

// File: rtl/alt_vipcti130_vid2is_seq.sv
// alt_vipcti130_vid2is_seq: Vid2IS capture sequencer; define VID2IS_SEQ_WATCHDOG_EN for the WAIT_SOF watchdog
module alt_vipcti130_vid2is_seq
  import alt_vipcti130_vid2is_pkg::*;
#(
  parameter int USED_WORDS_WIDTH = 15,
  parameter int STABLE_CYCLES    = 16,
  parameter int INTERLACED       = 1
`ifdef VID2IS_SEQ_WATCHDOG_EN
  , parameter int WATCHDOG_CYCLES = 2**20
`endif
) (
  input logic clk,
  input logic rst_n,
  alt_vipcti130_vid2is_seq_if.slave bus
);
  seq_state_e st, nst;
  logic good, armed, take_sof, clr_d, inc_d, wd_hit;
  assign good = bus.stable && bus.resolution_valid;
  assign take_sof = bus.sof && (INTERLACED == 0 || !bus.field);
  assign bus.state = st;
  alt_vipcti130_vid2is_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk(clk), .rst_n(rst_n), .run(st == S_WAIT_STABLE), .good(good), .armed(armed)
  );
`ifdef VID2IS_SEQ_WATCHDOG_EN
  logic [20:0] wd_cnt;
  assign wd_hit = wd_cnt == 21'(WATCHDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_cnt <= '0;
      bus.timeout_irq <= 1'b0;
    end else begin
      wd_cnt <= st == S_WAIT_SOF && nst == S_WAIT_SOF ? wd_cnt + 21'd1 : '0;
      bus.timeout_irq <= st == S_WAIT_SOF && bus.stable && nst == S_WAIT_STABLE;
    end
`else
  assign wd_hit = 1'b0;
  assign bus.timeout_irq = 1'b0;
`endif
  always_comb begin
    nst = st;
    clr_d = 1'b0;
    inc_d = 1'b0;
    case (st)
      S_IDLE:        nst = bus.enable ? S_WAIT_STABLE : S_IDLE;
      S_WAIT_STABLE: nst = !bus.enable ? S_IDLE : armed ? S_WAIT_SOF : S_WAIT_STABLE;
      S_WAIT_SOF:    nst = !bus.stable ? S_WAIT_STABLE : !bus.enable ? S_IDLE :
                           take_sof ? S_RUN : wd_hit ? S_WAIT_STABLE : S_WAIT_SOF;
      S_RUN:         nst = bus.overflow_sticky || !good ? S_FLUSH : !bus.enable ? S_STOP : S_RUN;
      S_STOP:        nst = bus.overflow_sticky ? S_FLUSH : bus.sof ? S_IDLE : S_STOP;
      S_FLUSH: begin
        clr_d = bus.usedw == USED_WORDS_WIDTH'(0);
        nst = clr_d ? S_RECOVER : S_FLUSH;
      end
      S_RECOVER: begin
        inc_d = !bus.overflow_sticky;
        nst = !inc_d ? S_RECOVER : bus.enable ? S_WAIT_STABLE : S_IDLE;
      end
      default:       nst = S_IDLE;
    endcase
  end
  // outputs decode the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      bus.fifo_write_en <= 1'b0;
      bus.is_output_enable <= 1'b0;
      bus.fifo_flush <= 1'b0;
      bus.clear_overflow_sticky <= 1'b0;
      bus.restart_count <= '0;
    end else begin
      st <= nst;
      bus.fifo_write_en <= nst == S_RUN || nst == S_STOP;
      bus.is_output_enable <= nst == S_RUN || nst == S_STOP;
      bus.fifo_flush <= nst == S_FLUSH;
      bus.clear_overflow_sticky <= clr_d;
      if (inc_d) bus.restart_count <= sat_inc(bus.restart_count);
    end
endmodule

// File: tb/tb_alt_vipcti130_vid2is_seq.sv
// tb_alt_vipcti130_vid2is_seq: directed and random checks of the capture sequencer against a cycle model
module tb_alt_vipcti130_vid2is_seq;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0, n_err = 0;
  int ms, streak, mrc, n;
  bit m_we, m_oe, m_fl, m_clr, clr_prev;

  always #5 clk = ~clk;

  alt_vipcti130_vid2is_seq_if #(.USED_WORDS_WIDTH(15)) bus ();
  alt_vipcti130_vid2is_seq #(.USED_WORDS_WIDTH(15), .STABLE_CYCLES(SC), .INTERLACED(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; streak = 0; mrc = 0;
    m_we = 0; m_oe = 0; m_fl = 0; m_clr = 0; clr_prev = 0;
  endtask

  // state numbers: 0 idle, 1 wait stable, 2 wait sof, 3 run, 4 stop, 5 flush, 6 recover
  task automatic model_clk();
    int ns;
    bit good;
    good = bus.stable && bus.resolution_valid;
    ns = ms;
    m_clr = 0;
    streak = (ms == 1 && good) ? streak + 1 : 0;
    if (ms == 0) begin
      if (bus.enable) ns = 1;
    end else if (ms == 1) begin
      if (!bus.enable) ns = 0;
      else if (streak >= SC) ns = 2;
    end else if (ms == 2) begin
      if (!bus.stable) ns = 1;
      else if (!bus.enable) ns = 0;
      else if (bus.sof && !bus.field) ns = 3;
    end else if (ms == 3) begin
      if (bus.overflow_sticky || !good) ns = 5;
      else if (!bus.enable) ns = 4;
    end else if (ms == 4) begin
      if (bus.overflow_sticky) ns = 5;
      else if (bus.sof) ns = 0;
    end else if (ms == 5) begin
      if (bus.usedw == 0) begin ns = 6; m_clr = 1; end
    end else if (ms == 6) begin
      if (!bus.overflow_sticky) begin
        mrc = mrc == 255 ? 255 : mrc + 1;
        ns = bus.enable ? 1 : 0;
      end
    end
    if (ns != 1) streak = 0;
    ms = ns;
    m_we = ns == 3 || ns == 4;
    m_oe = ns == 3 || ns == 4;
    m_fl = ns == 5;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
    chk("state", bus.state, ms);
    chk("fifo_write_en", bus.fifo_write_en, m_we);
    if (ms != 4) chk("is_output_enable", bus.is_output_enable, m_oe);
    chk("fifo_flush", bus.fifo_flush, m_fl);
    chk("clear_overflow_sticky", bus.clear_overflow_sticky, m_clr);
    chk("restart_count", bus.restart_count, mrc);
    chk("timeout_irq", bus.timeout_irq, 0);
    // sticky flag clears on the edge that samples the clear pulse; the FIFO drains while flushed
    if (clr_prev) bus.overflow_sticky = 0;
    clr_prev = m_clr;
    if (m_fl && bus.usedw != 0) bus.usedw = bus.usedw - 15'd1;
  endtask

  task automatic step(input bit en, input bit st, input bit vl, input bit sf, input bit fd);
    bus.enable = en; bus.stable = st; bus.resolution_valid = vl; bus.sof = sf; bus.field = fd;
    tick();
  endtask

  task automatic to_run();
    for (int i = 0; i < 12 && ms != 3; i++) step(1, 1, 1, ms == 2, 0);
  endtask

  initial begin
    rst_n = 1;
    bus.enable = 0; bus.stable = 0; bus.resolution_valid = 0; bus.sof = 0; bus.field = 0;
    bus.overflow_sticky = 0; bus.usedw = '0;
    model_reset();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_we", bus.fifo_write_en, 0);
    chk("rst_flush", bus.fifo_flush, 0);
    chk("rst_oe", bus.is_output_enable, 0);
    chk("rst_clr", bus.clear_overflow_sticky, 0);
    chk("rst_rc", bus.restart_count, 0);
    chk("rst_irq", bus.timeout_irq, 0);
    rst_n = 1;
    // arming
    step(1, 1, 1, 0, 0); chk("arm_wait_stable", bus.state, 1);
    repeat (3) step(1, 1, 1, 0, 0); chk("arm_hold", bus.state, 1);
    step(1, 1, 1, 0, 0); chk("arm_wait_sof", bus.state, 2);
    step(1, 1, 1, 1, 1); chk("arm_field1_ignored", bus.state, 2); chk("arm_we_pre", bus.fifo_write_en, 0);
    step(1, 1, 1, 1, 0); chk("arm_run", bus.state, 3); chk("arm_we", bus.fifo_write_en, 1);
    repeat (3) step(1, 1, 1, 0, 0);
    // graceful stop
    step(0, 1, 1, 0, 0); chk("stop_state", bus.state, 4); chk("stop_we", bus.fifo_write_en, 1);
    repeat (3) step(0, 1, 1, 0, 0); chk("stop_we_hold", bus.fifo_write_en, 1);
    step(0, 1, 1, 1, 1); chk("stop_idle", bus.state, 0); chk("stop_we_drop", bus.fifo_write_en, 0);
    // stable glitch restarts the persistence count
    step(1, 1, 1, 0, 0);
    repeat (3) step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0); chk("glitch_stay", bus.state, 1);
    repeat (3) step(1, 1, 1, 0, 0); chk("glitch_hold", bus.state, 1);
    step(1, 1, 1, 0, 0); chk("glitch_wait_sof", bus.state, 2);
    step(1, 1, 1, 1, 0);
    // overflow in RUN
    bus.overflow_sticky = 1; bus.usedw = 15'd5;
    step(1, 1, 1, 0, 0);
    chk("ovf_flush", bus.state, 5); chk("ovf_we", bus.fifo_write_en, 0); chk("ovf_flush_out", bus.fifo_flush, 1);
    n = 0;
    for (int i = 0; i < 20 && ms != 1; i++) begin
      step(1, 1, 1, 0, 0);
      if (bus.clear_overflow_sticky === 1'b1) n++;
    end
    chk("ovf_clr_pulses", n, 1); chk("ovf_rc", bus.restart_count, 1); chk("ovf_state", bus.state, 1);
    // overflow during STOP
    to_run();
    step(0, 1, 1, 0, 0);
    bus.overflow_sticky = 1; bus.usedw = 15'd2;
    step(0, 1, 1, 0, 0); chk("stop_ovf_flush", bus.state, 5);
    for (int i = 0; i < 20 && ms != 0; i++) step(0, 1, 1, 0, 0);
    chk("stop_ovf_idle", bus.state, 0); chk("stop_ovf_rc", bus.restart_count, 2);
    // async reset mid-FLUSH
    to_run();
    bus.overflow_sticky = 1; bus.usedw = 15'd9;
    step(1, 1, 1, 0, 0); chk("pre_rst_flush", bus.state, 5);
    #2 rst_n = 0;
    #1;
    chk("arst_state", bus.state, 0); chk("arst_flush", bus.fifo_flush, 0);
    chk("arst_we", bus.fifo_write_en, 0); chk("arst_oe", bus.is_output_enable, 0);
    chk("arst_rc", bus.restart_count, 0);
    model_reset();
    bus.overflow_sticky = 0; bus.usedw = '0;
    @(posedge clk);
    #1 rst_n = 1;
    // random traffic
    repeat (1500) begin
      if ((ms == 3 || ms == 4) && !bus.overflow_sticky && $urandom_range(0, 24) == 0) begin
        bus.overflow_sticky = 1;
        bus.usedw = 15'($urandom_range(0, 6));
      end
      step($urandom_range(0, 15) != 0, $urandom_range(0, 19) != 0, $urandom_range(0, 29) != 0,
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
    // restart_count saturation
    rst_n = 0;
    model_reset();
    bus.overflow_sticky = 0; bus.usedw = '0;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (2600) begin
      if (ms == 3 && !bus.overflow_sticky) begin
        bus.overflow_sticky = 1;
        bus.usedw = '0;
      end
      step(1, 1, 1, ms == 2, 0);
    end
    chk("rc_saturated", bus.restart_count, 255);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
